// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment width, dp position
// and the hex-to-segment table (active-high, bit order gfedcba).
package seg7_pkg;

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned DP_BIT = 7;

    // Entry k is the pattern for nibble value k; packed so index 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       dp;
        logic [6:0] segs;
    } seg_pattern_t;

    function automatic logic [SEG_W-1:0] apply_polarity(input logic [SEG_W-1:0] raw,
                                                        input bit active_low);
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high gfedcba segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-aligned (tear-free) value updates.
// Optional leading-zero blanking is built when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] VALUE_IN,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic                    LOAD,
    output logic [SEG_W-1:0]        SEG,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    FRAME_DONE
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SEG_W-1:0]      SEG_OFF = ACTIVE_LOW ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;

    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("REFRESH_DIV must be at least 2");
    end

    logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [VAL_W-1:0]      disp_value_q, disp_value_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [VAL_W-1:0]      pend_value_q, pend_value_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_flag_q, pend_flag_d;
    logic                  bnd_q;
    logic                  frame_done_q;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  last_div;
    logic                  last_digit;
    logic                  boundary;
    logic [3:0]            cur_nibble;
    logic [6:0]            cur_segs;
    seg_pattern_t          seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;
    logic [NUM_DIGITS-1:0] lz_blank;

    assign last_div   = (div_cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign last_digit = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
    assign boundary   = last_div && last_digit;

    always_comb begin
        div_cnt_d    = last_div ? '0 : div_cnt_q + CNT_W'(1);
        digit_idx_d  = digit_idx_q;
        disp_value_d = disp_value_q;
        disp_dp_d    = disp_dp_q;
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_flag_d  = pend_flag_q;

        if (last_div) begin
            digit_idx_d = last_digit ? '0 : digit_idx_q + IDX_W'(1);
        end

        // A LOAD landing on the boundary bypasses pending and supersedes any older pending value.
        if (LOAD && boundary) begin
            disp_value_d = VALUE_IN;
            disp_dp_d    = DP_IN;
            pend_flag_d  = 1'b0;
        end else if (LOAD) begin
            pend_value_d = VALUE_IN;
            pend_dp_d    = DP_IN;
            pend_flag_d  = 1'b1;
        end else if (boundary && pend_flag_q) begin
            disp_value_d = pend_value_q;
            disp_dp_d    = pend_dp_q;
            pend_flag_d  = 1'b0;
        end
    end

    assign cur_nibble = disp_value_q[digit_idx_q * 4 +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .segs   (cur_segs)
    );

    // Digit k is a leading zero when it and every digit above it are zero with no dp.
    always_comb begin
        lz_blank = '0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            lz_blank[k] = ((disp_value_q >> (4 * k)) == '0) && !disp_dp_q[k];
        end
    end

    always_comb begin
        seg_raw.dp          = disp_dp_q[digit_idx_q];
        seg_raw.segs        = cur_segs;
        an_raw              = '0;
        an_raw[digit_idx_q] = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
        if (lz_blank[digit_idx_q]) begin
            an_raw = '0;
        end
`endif
        seg_d = apply_polarity(seg_raw, ACTIVE_LOW);
        an_d  = ACTIVE_LOW ? ~an_raw : an_raw;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            disp_value_q <= '0;
            disp_dp_q    <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            bnd_q        <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            disp_value_q <= disp_value_d;
            disp_dp_q    <= disp_dp_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            // Two stages so the pulse lines up with digit 0 reaching the registered AN.
            bnd_q        <= boundary;
            frame_done_q <= bnd_q;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign SEG        = seg_q;
    assign AN         = an_q;
    assign FRAME_DONE = frame_done_q;

endmodule
